if_prefetch_queue: RTL and testbench

//  Instruction-fetch front end feeding the decoder. Owns the PC, issues sequential word fetches to the

---
 rtl/scc_pkg.sv | 14 +
 rtl/if_prefetch_queue_if.sv | 25 ++
 rtl/scc_sync_fifo.sv | 57 +++++
 rtl/if_prefetch_queue.sv | 80 ++++++++
 tb/tb_if_prefetch_queue.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/scc_pkg.sv
// Shared fetch-path types and widths, used by the prefetch queue and its FIFO.
package scc_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory and decode-side signals of the fetch front end.
interface if_prefetch_queue_if;
    import scc_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_req;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output imem_addr, imem_req, instr, instr_pc, instr_valid,
        input  imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_addr, imem_req, instr, instr_pc, instr_valid,
        output imem_rdata, redirect, redirect_pc, instr_ready
    );

endinterface

// File: rtl/scc_sync_fifo.sv
// Generic synchronous FIFO with flush; head entry is visible without a pop.
module scc_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign do_pop    = pop & ~empty;
    assign head_data = mem[head];

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)   tail <= tail + 1'b1;
            if (do_pop) head <= head + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch front end: owns the PC, issues sequential fetches and queues returned words for decode.
module if_prefetch_queue
    import scc_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned       PC_INC   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    if_prefetch_queue_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight_v;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    logic              empty;
    logic              full;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    fetch_entry_t      hold_entry;

    // Counting the in-flight slot reserves room for its return before issuing.
    assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight_v};
    assign issue      = reset & ~bus.redirect & (occupancy < (CNT_W+1)'(DEPTH));
    assign push       = inflight_v & ~bus.redirect;
    assign pop        = bus.instr_ready & ~empty;
    assign push_entry = '{pc: inflight_pc, word: bus.imem_rdata};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
            hold_entry  <= '0;
        end else begin
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
            end
            inflight_v <= issue;
            if (issue) inflight_pc <= fetch_pc;
            // Remembers the last head shown so outputs hold once the queue drains.
            if (!empty) hold_entry <= head_entry;
        end
    end

    scc_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect),
        .head_data (head_entry),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign bus.imem_addr   = fetch_pc;
    assign bus.imem_req    = issue;
    assign bus.instr_valid = ~empty;
    assign bus.instr       = empty ? hold_entry.word : head_entry.word;
    assign bus.instr_pc    = empty ? hold_entry.pc   : head_entry.pc;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) push |-> !full);

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: cycle table for handshakes plus a fetch/pop scoreboard.
module tb_if_prefetch_queue;
    import scc_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk;
    logic reset;

    if_prefetch_queue_if bus();

    if_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_INC   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          n;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic        exp_valid;
        logic        chk_pc;
        logic [31:0] exp_pc;
    } row_t;

    row_t        rows[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] sb_q[$];
    logic [31:0] sb_fetch_pc;
    logic        req_q;
    logic [31:0] addr_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(int n, logic rdy, logic rd, logic [31:0] rpc,
                                logic er, logic ev, logic cp, logic [31:0] ep);
        rows.push_back('{n, rdy, rd, rpc, er, ev, cp, ep});
    endfunction

    // One cycle: drive at edge+1, sample at edge+2, memory answers the captured request at next edge+1.
    task automatic run_cycle(input row_t r);
        logic [31:0] p;
        bus.instr_ready = r.ready;
        bus.redirect    = r.redir;
        bus.redirect_pc = r.rpc;
        #1;
        check("imem_req", bus.imem_req, r.exp_req);
        check("instr_valid", bus.instr_valid, r.exp_valid);
        if (r.chk_pc) begin
            check("instr_pc_hold", bus.instr_pc, r.exp_pc);
            check("instr_hold", bus.instr, r.exp_pc ^ KEY);
        end
        if (bus.imem_req) begin
            check("imem_addr", bus.imem_addr, sb_fetch_pc);
            sb_q.push_back(sb_fetch_pc);
            sb_fetch_pc = sb_fetch_pc + 32'd4;
        end
        if (bus.instr_valid && r.ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pop_pc", bus.instr_pc, 32'hXXXX_XXXX);
            end else begin
                p = sb_q.pop_front();
                check("pop_pc", bus.instr_pc, p);
                check("pop_word", bus.instr, p ^ KEY);
            end
        end
        if (r.redir) begin
            sb_q.delete();
            sb_fetch_pc = r.rpc;
        end
        req_q  = bus.imem_req;
        addr_q = bus.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rdata = req_q ? (addr_q ^ KEY) : 32'hDEAD_BEEF;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sb_fetch_pc = 32'h0;

        // n  rdy red rpc            req val chk pc
        add(1, 1, 0, 32'h0,          1,  0,  0,  32'h0);         // issue at cycle 0
        add(1, 1, 0, 32'h0,          1,  0,  0,  32'h0);
        add(4, 1, 0, 32'h0,          1,  1,  0,  32'h0);         // 0,4,8,12 back to back
        add(2, 0, 0, 32'h0,          1,  1,  1,  32'h10);        // stall, queue fills
        add(8, 0, 0, 32'h0,          0,  1,  1,  32'h10);        // full: no issue, head stable
        add(1, 1, 0, 32'h0,          0,  1,  1,  32'h10);        // pop frees a slot
        add(4, 1, 0, 32'h0,          1,  1,  0,  32'h0);         // resumes next cycle
        add(1, 0, 0, 32'h0,          1,  1,  1,  32'h24);
        add(1, 0, 1, 32'h100,        0,  1,  1,  32'h24);        // redirect: 3 queued + 1 in flight
        add(2, 1, 0, 32'h0,          1,  0,  1,  32'h24);        // flushed, outputs hold
        add(3, 1, 0, 32'h0,          1,  1,  0,  32'h0);         // 100,104,108
        add(1, 1, 1, 32'hFFFF_FFFC,  0,  1,  1,  32'h10C);       // redirect with pop of 10C
        add(2, 1, 0, 32'h0,          1,  0,  1,  32'h10C);
        add(3, 1, 0, 32'h0,          1,  1,  0,  32'h0);         // FFFFFFFC, 0, 4
        add(2, 0, 0, 32'h0,          1,  1,  1,  32'h8);
        add(2, 0, 0, 32'h0,          0,  1,  1,  32'h8);         // full again

        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("reset_imem_req", bus.imem_req, 1'b0);
        check("reset_instr_valid", bus.instr_valid, 1'b0);
        check("reset_imem_addr", bus.imem_addr, 32'h0);
        check("reset_instr", bus.instr, 32'h0);
        check("reset_instr_pc", bus.instr_pc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        foreach (rows[i]) begin
            for (int k = 0; k < rows[i].n; k++) begin
                run_cycle(rows[i]);
            end
        end

        // Asynchronous reset with the queue full and mid-cycle.
        bus.instr_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midreset_imem_req", bus.imem_req, 1'b0);
        check("midreset_instr_valid", bus.instr_valid, 1'b0);
        check("midreset_imem_addr", bus.imem_addr, 32'h0);
        check("midreset_instr_pc", bus.instr_pc, 32'h0);
        check("midreset_instr", bus.instr, 32'h0);
        @(posedge clk);
        #1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        reset = 1'b1;
        sb_q.delete();
        sb_fetch_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < rows[i].n; k++) begin
                run_cycle(rows[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
